// File: rtl/reg_file_rs.sv
// reg_file_rs: register file, PC sequencer and return-address stack for the small CPU
//
// Ports:
//   clock, reset_n          rising-edge clock, synchronous active-low reset
//   opcode, raddr1, raddr2  instruction opcode and read addresses (also LDI immediate)
//   waddr                   write address; its low 4 bits are the sub-op for 111x
//   alu_out, E_out          ALU result and carry/error flag
//   dmem_out                data memory read data
//   gpi, gpi_we             general input data and its valid strobe
//   stall                   freezes PC, stack, registers and E this cycle
//   a, b                    combinational register reads
//   pc, gpo, mem_addr       architectural views of PC, GPO and memory address registers
//   dmem_we, vmem_we        combinational memory write strobes
//   E, F, gpi_ovf, rs_err   status flags
module reg_file_rs #(
  parameter int DW = 8,
  parameter int NREG = 16,
  parameter int RS_DEPTH = 4,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [3:0]    opcode,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] alu_out,
  input  logic          E_out,
  input  logic [DW-1:0] dmem_out,
  input  logic [DW-1:0] gpi,
  input  logic          gpi_we,
  input  logic          stall,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [DW-1:0] pc,
  output logic [DW-1:0] gpo,
  output logic [2*DW-1:0] mem_addr,
  output logic          dmem_we,
  output logic          vmem_we,
  output logic          E,
  output logic          F,
  output logic          gpi_ovf,
  output logic          rs_err
);
  localparam int PCI = NREG - 1;
  localparam int RAI = NREG - 2;
  localparam int GPII = NREG - 3;
  localparam int GPOI = NREG - 4;
  localparam int MHI = NREG - 5;
  localparam int MLO = NREG - 6;
  localparam int PW = RS_DEPTH > 1 ? $clog2(RS_DEPTH) : 1;
  localparam int CW = $clog2(RS_DEPTH + 1);
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] stk [RS_DEPTH];
  logic [PW-1:0] sp;
  logic [CW-1:0] cnt;
  logic [3:0] sub;
  logic [DW-1:0] wdata, pc1, pc2, pc_next, top;
  logic [PW-1:0] sp_inc, sp_dec;
  logic normal_op, call, op_ret, op_clf, op_cle, unsat, empty, gen_we, clf;
  always_comb begin
    sub = 4'(waddr);
    normal_op = opcode[3:1] != 3'b111;
    wdata = opcode == 4'b1100 ? DW'({raddr1, raddr2}) : opcode == 4'b1101 ? dmem_out : alu_out;
    call = normal_op && waddr == AW'(PCI);
    op_ret = opcode == 4'b1111 && sub == 4'b0011;
    op_clf = opcode == 4'b1111 && sub == 4'b0001;
    op_cle = opcode == 4'b1111 && sub == 4'b0010;
    unsat = opcode == 4'b1110 && (sub == 4'b0001 ? a != b :
                                  sub == 4'b0010 ? !(a > b) :
                                  sub == 4'b0100 ? !F :
                                  sub == 4'b1000 ? !E : 1'b0);
    empty = cnt == '0;
    sp_inc = sp == PW'(RS_DEPTH - 1) ? '0 : sp + 1'b1;
    sp_dec = sp == '0 ? PW'(RS_DEPTH - 1) : sp - 1'b1;
    top = stk[sp_dec];
    pc1 = pc + DW'(1);
    pc2 = pc + DW'(2);
    pc_next = call ? wdata : (op_ret && !empty) ? top : unsat ? pc2 : pc1;
    gen_we = normal_op && waddr != AW'(GPII) && waddr != AW'(RAI) && waddr != AW'(PCI);
    clf = op_clf && !stall;
    dmem_we = opcode == 4'b1111 && sub == 4'b1000 && !stall;
    vmem_we = opcode == 4'b1111 && sub == 4'b0100 && !stall;
    a = regs[raddr1];
    b = regs[raddr2];
    pc = regs[PCI];
    gpo = regs[GPOI];
    mem_addr = {regs[MHI], regs[MLO]};
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      sp <= '0;
      cnt <= '0;
      E <= 1'b0;
      F <= 1'b0;
      gpi_ovf <= 1'b0;
      rs_err <= 1'b0;
    end else begin
      if (!stall) begin
        regs[PCI] <= pc_next;
        if (call) begin
          // when full, sp already points at the oldest entry, so it is overwritten
          regs[RAI] <= pc1;
          stk[sp] <= pc1;
          sp <= sp_inc;
          cnt <= cnt == CW'(RS_DEPTH) ? cnt : cnt + 1'b1;
        end else if (op_ret && !empty) begin
          sp <= sp_dec;
          cnt <= cnt - 1'b1;
        end else if (op_ret) begin
          rs_err <= 1'b1;
        end
        if (gen_we) regs[waddr] <= wdata;
        E <= op_cle ? 1'b0 : E_out;
      end
      if (gpi_we) regs[GPII] <= gpi;
      // a clear in the same cycle as new input acts first, so no overrun is flagged
      F <= gpi_we | (F & !clf);
      gpi_ovf <= clf ? 1'b0 : gpi_ovf | (gpi_we & F);
    end
  end
endmodule

// File: tb/tb_reg_file_rs.sv
// tb_reg_file_rs: scoreboard bench for reg_file_rs (default and DW=16/NREG=32 instances)
module tb_reg_file_rs;
  logic clock = 1'b0;
  logic reset_n;
  logic [3:0] opcode, raddr1, raddr2, waddr;
  logic [7:0] alu_out, dmem_out, gpi;
  logic E_out, gpi_we, stall;
  logic [7:0] a, b, pc, gpo;
  logic [15:0] mem_addr;
  logic dmem_we, vmem_we, E, F, gpi_ovf, rs_err;
  logic [3:0] p_opcode;
  logic [4:0] p_r1, p_r2, p_w;
  logic [15:0] p_alu, p_a, p_b, p_pc, p_gpo;
  logic [31:0] p_mem_addr;
  logic p_dmem_we, p_vmem_we, p_E, p_F, p_ovf, p_rs_err;
  typedef struct {
    int id;
    string nm;
    logic [31:0] v;
  } chk_t;
  chk_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  reg_file_rs u0 (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .raddr1(raddr1), .raddr2(raddr2),
    .waddr(waddr), .alu_out(alu_out), .E_out(E_out), .dmem_out(dmem_out), .gpi(gpi),
    .gpi_we(gpi_we), .stall(stall), .a(a), .b(b), .pc(pc), .gpo(gpo), .mem_addr(mem_addr),
    .dmem_we(dmem_we), .vmem_we(vmem_we), .E(E), .F(F), .gpi_ovf(gpi_ovf), .rs_err(rs_err)
  );
  reg_file_rs #(.DW(16), .NREG(32), .RS_DEPTH(4)) u1 (
    .clock(clock), .reset_n(reset_n), .opcode(p_opcode), .raddr1(p_r1), .raddr2(p_r2),
    .waddr(p_w), .alu_out(p_alu), .E_out(1'b0), .dmem_out(16'h0), .gpi(16'h0),
    .gpi_we(1'b0), .stall(1'b0), .a(p_a), .b(p_b), .pc(p_pc), .gpo(p_gpo),
    .mem_addr(p_mem_addr), .dmem_we(p_dmem_we), .vmem_we(p_vmem_we), .E(p_E), .F(p_F),
    .gpi_ovf(p_ovf), .rs_err(p_rs_err)
  );
  localparam int I_PC = 0, I_A = 1, I_E = 2, I_F = 3, I_OVF = 4, I_RSE = 5, I_DWE = 6,
                 I_VWE = 7, I_GPO = 8, I_MA = 9, I_PPC = 10, I_PA = 11, I_PMA = 12;
  initial forever begin
    @(negedge clock);
    while (sb.size() > 0) begin
      chk_t e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.id)
        I_PC: act = 32'(pc);
        I_A: act = 32'(a);
        I_E: act = 32'(E);
        I_F: act = 32'(F);
        I_OVF: act = 32'(gpi_ovf);
        I_RSE: act = 32'(rs_err);
        I_DWE: act = 32'(dmem_we);
        I_VWE: act = 32'(vmem_we);
        I_GPO: act = 32'(gpo);
        I_MA: act = 32'(mem_addr);
        I_PPC: act = 32'(p_pc);
        I_PA: act = 32'(p_a);
        default: act = p_mem_addr;
      endcase
      n_chk++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h at %0t", e.nm, act, e.v, $time);
      end
    end
  end
  task automatic expect_v(input int id, input string nm, input logic [31:0] v);
    sb.push_back('{id, nm, v});
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic set(input logic [3:0] op, input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] w);
    opcode = op;
    raddr1 = r1;
    raddr2 = r2;
    waddr = w;
    stall = 1'b0;
    gpi_we = 1'b0;
  endtask
  task automatic p_set(input logic [3:0] op, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] w);
    p_opcode = op;
    p_r1 = r1;
    p_r2 = r2;
    p_w = w;
  endtask
  task automatic peek(input logic [3:0] r, input logic [7:0] v);
    set(4'hF, r, 4'h0, 4'h0);
    stall = 1'b1;
    expect_v(I_A, $sformatf("reg%0d", r), 32'(v));
    tick();
  endtask
  task automatic step_pc(input logic [3:0] op, input logic [3:0] r1, input logic [3:0] r2,
                         input logic [3:0] w, input logic [7:0] pc_before);
    set(op, r1, r2, w);
    expect_v(I_PC, "pc", 32'(pc_before));
    tick();
  endtask
  initial begin
    int ret_pc[5];
    ret_pc = '{6, 6, 5, 4, 3};
    reset_n = 1'b0;
    set(4'hC, 4'hF, 4'hF, 4'hF);
    gpi_we = 1'b1;
    gpi = 8'hFF;
    E_out = 1'b1;
    alu_out = 8'h0;
    dmem_out = 8'h0;
    p_alu = 16'h0;
    p_set(4'hF, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    reset_n = 1'b1;
    set(4'hF, 4'h0, 4'h0, 4'h0);
    E_out = 1'b0;
    expect_v(I_PC, "rst_pc", 0);
    expect_v(I_E, "rst_E", 0);
    expect_v(I_F, "rst_F", 0);
    expect_v(I_OVF, "rst_ovf", 0);
    expect_v(I_RSE, "rst_rs_err", 0);
    expect_v(I_GPO, "rst_gpo", 0);
    expect_v(I_MA, "rst_mem_addr", 0);
    tick();
    step_pc(4'hF, 4'h0, 4'h0, 4'h0, 8'h01);
    expect_v(I_PC, "pc_count", 2);
    peek(4'd3, 8'h00);
    peek(4'd13, 8'h00);
    peek(4'd14, 8'h00);
    for (int i = 0; i < 14; i++) begin
      set(4'hF, 4'h0, 4'h0, 4'h0);
      tick();
    end
    step_pc(4'hC, 4'h4, 4'h0, 4'hF, 8'h10);
    peek(4'd14, 8'h11);
    step_pc(4'hF, 4'h0, 4'h0, 4'h3, 8'h40);
    set(4'hF, 4'h0, 4'h0, 4'h3);
    expect_v(I_PC, "ret_pc", 32'h11);
    expect_v(I_RSE, "rs_err_pre", 0);
    tick();
    set(4'hF, 4'h0, 4'h0, 4'h0);
    expect_v(I_PC, "ret_empty_pc", 32'h12);
    expect_v(I_RSE, "rs_err_set", 1);
    tick();
    step_pc(4'hC, 4'h5, 4'hA, 4'h3, 8'h13);
    peek(4'd3, 8'h5A);
    step_pc(4'hE, 4'h3, 4'h3, 4'h1, 8'h14);
    step_pc(4'hE, 4'h3, 4'h0, 4'h1, 8'h15);
    step_pc(4'hC, 4'h8, 4'h0, 4'h1, 8'h17);
    step_pc(4'hC, 4'h7, 4'hF, 4'h2, 8'h18);
    step_pc(4'hE, 4'h1, 4'h2, 4'h2, 8'h19);
    step_pc(4'hE, 4'h2, 4'h1, 4'h2, 8'h1A);
    step_pc(4'hE, 4'h0, 4'h0, 4'h4, 8'h1C);
    step_pc(4'hE, 4'h0, 4'h0, 4'h3, 8'h1E);
    E_out = 1'b1;
    step_pc(4'hF, 4'h0, 4'h0, 4'h0, 8'h1F);
    set(4'hE, 4'h0, 4'h0, 4'h8);
    expect_v(I_E, "E_set", 1);
    expect_v(I_PC, "pc", 32'h20);
    tick();
    step_pc(4'hF, 4'h0, 4'h0, 4'h2, 8'h21);
    E_out = 1'b0;
    set(4'hF, 4'h0, 4'h0, 4'h0);
    expect_v(I_E, "E_cle", 0);
    expect_v(I_PC, "pc", 32'h22);
    tick();
    reset_n = 1'b0;
    set(4'hF, 4'h0, 4'h0, 4'h0);
    tick();
    reset_n = 1'b1;
    expect_v(I_PC, "rst2_pc", 0);
    expect_v(I_RSE, "rst2_rs_err", 0);
    tick();
    for (int k = 2; k <= 6; k++) step_pc(4'hC, 4'h0, 4'(k), 4'hF, 8'(k - 1));
    peek(4'd14, 8'h06);
    for (int k = 0; k < 5; k++) begin
      set(4'hF, 4'h0, 4'h0, 4'h3);
      expect_v(I_PC, $sformatf("ovf_ret%0d", k), 32'(ret_pc[k]));
      if (k == 4) expect_v(I_RSE, "rs_err_pre5", 0);
      tick();
    end
    set(4'hF, 4'h0, 4'h0, 4'h0);
    expect_v(I_PC, "ret5_pc", 4);
    expect_v(I_RSE, "rs_err_ret5", 1);
    tick();
    set(4'hF, 4'h0, 4'h0, 4'h0);
    gpi_we = 1'b1;
    gpi = 8'h33;
    expect_v(I_PC, "pc", 5);
    tick();
    set(4'hF, 4'h0, 4'h0, 4'h0);
    expect_v(I_F, "F_gpi", 1);
    expect_v(I_OVF, "ovf_first", 0);
    tick();
    peek(4'd13, 8'h33);
    set(4'hF, 4'h0, 4'h0, 4'h0);
    gpi_we = 1'b1;
    gpi = 8'h44;
    tick();
    set(4'hF, 4'h0, 4'h0, 4'h0);
    expect_v(I_OVF, "ovf_second", 1);
    expect_v(I_F, "F_second", 1);
    tick();
    peek(4'd13, 8'h44);
    step_pc(4'hC, 4'h9, 4'h9, 4'hD, 8'h09);
    peek(4'd13, 8'h44);
    set(4'hF, 4'h0, 4'h0, 4'h1);
    tick();
    set(4'hF, 4'h0, 4'h0, 4'h0);
    expect_v(I_F, "F_clf", 0);
    expect_v(I_OVF, "ovf_clf", 0);
    expect_v(I_PC, "pc", 32'h0B);
    tick();
    set(4'hF, 4'h0, 4'h0, 4'h0);
    gpi_we = 1'b1;
    gpi = 8'h55;
    tick();
    set(4'hF, 4'h0, 4'h0, 4'h1);
    gpi_we = 1'b1;
    gpi = 8'h66;
    tick();
    set(4'hF, 4'h0, 4'h0, 4'h0);
    expect_v(I_F, "F_clf_gpi", 1);
    expect_v(I_OVF, "ovf_clf_gpi", 0);
    expect_v(I_PC, "pc", 32'h0E);
    tick();
    peek(4'd13, 8'h66);
    step_pc(4'hC, 4'hC, 4'h3, 4'hC, 8'h0F);
    set(4'hC, 4'h1, 4'h2, 4'hB);
    expect_v(I_GPO, "gpo", 32'hC3);
    tick();
    set(4'hC, 4'h3, 4'h4, 4'hA);
    tick();
    set(4'hF, 4'h0, 4'h0, 4'h0);
    expect_v(I_MA, "mem_addr", 32'h1234);
    expect_v(I_PC, "pc", 32'h12);
    tick();
    set(4'hF, 4'h0, 4'h0, 4'h8);
    expect_v(I_DWE, "dmw_we", 1);
    expect_v(I_VWE, "dmw_vwe", 0);
    tick();
    set(4'hF, 4'h0, 4'h0, 4'h4);
    expect_v(I_VWE, "vmw_we", 1);
    expect_v(I_DWE, "vmw_dwe", 0);
    tick();
    set(4'hF, 4'h0, 4'h0, 4'h8);
    stall = 1'b1;
    expect_v(I_DWE, "stall_dwe", 0);
    expect_v(I_PC, "stall_pc", 32'h15);
    tick();
    set(4'hC, 4'h7, 4'h7, 4'hF);
    stall = 1'b1;
    gpi_we = 1'b1;
    gpi = 8'hAB;
    E_out = 1'b1;
    tick();
    set(4'hC, 4'h1, 4'h1, 4'h3);
    stall = 1'b1;
    expect_v(I_PC, "stall_ldi_pc", 32'h15);
    tick();
    set(4'hF, 4'h0, 4'h0, 4'h1);
    stall = 1'b1;
    tick();
    peek(4'd3, 8'h00);
    peek(4'd13, 8'hAB);
    E_out = 1'b0;
    set(4'hF, 4'h0, 4'h0, 4'h0);
    expect_v(I_E, "stall_E", 0);
    expect_v(I_F, "stall_clf_F", 1);
    expect_v(I_OVF, "stall_ovf", 1);
    expect_v(I_PC, "stall_hold_pc", 32'h15);
    expect_v(I_MA, "stall_mem_addr", 32'h1234);
    tick();
    step_pc(4'hF, 4'h0, 4'h0, 4'h0, 8'h16);
    p_set(4'hC, 5'h1F, 5'h1F, 5'd27);
    tick();
    p_set(4'hC, 5'h01, 5'h02, 5'd26);
    tick();
    p_set(4'h0, 5'd27, 5'd0, 5'd31);
    p_alu = 16'hFFFF;
    expect_v(I_PA, "p_imm10", 32'h3FF);
    expect_v(I_PMA, "p_mem_addr", 32'h03FF0022);
    tick();
    p_set(4'hF, 5'd0, 5'd0, 5'd0);
    expect_v(I_PPC, "p_pc_max", 32'hFFFF);
    tick();
    expect_v(I_PPC, "p_pc_wrap", 0);
    tick();
    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_rs.md
Name: reg_file_rs

Overview:
- Parametrised next-generation register file and program-sequencing unit for the small accumulator-less CPU.
- Generalises data width and register count, and adds a hardware return-address stack with a RET instruction.
- Adds a stall input, a GPI overrun flag and corrected conditional-jump compares.
- Sits between decode, ALU, data/video memory and GPIO, and owns the PC.

Parameters:
DW, 8, data/register width (DW >= 2*AW)
NREG, 16, number of registers (power of 2, >= 8); AW = clog2(NREG)
RS_DEPTH, 4, return-address stack entries (>= 1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  synchronous, active-low reset
opcode  in  4  instruction opcode
raddr1  in  AW  read address A / immediate high part
raddr2  in  AW  read address B / immediate low part
waddr  in  AW  write address / sub-opcode (low 4 bits used as sub-op)
alu_out  in  DW  ALU result
E_out  in  1  ALU carry/error flag
dmem_out  in  DW  data memory read data
gpi  in  DW  keyboard/general input data
gpi_we  in  1  gpi valid strobe
stall  in  1  freeze pipeline state this cycle
a  out  DW  reg[raddr1], combinational
b  out  DW  reg[raddr2], combinational (also memory write data)
pc  out  DW  reg[PCI]
gpo  out  DW  reg[GPOI]
mem_addr  out  2*DW  {reg[MHI], reg[MLO]}
dmem_we  out  1  data memory write strobe
vmem_we  out  1  video memory write strobe
E  out  1  registered error/carry flag
F  out  1  registered input-pending flag
gpi_ovf  out  1  sticky: gpi arrived while F=1
rs_err  out  1  sticky: RET on empty stack

Behaviour:
- Reset: while reset_n=0 at a clock edge, all registers, E, F, gpi_ovf and rs_err go to 0 and the stack becomes empty. Outputs follow: pc=0, gpo=0, mem_addr=0. Reset overrides stall and gpi_we.
- Fixed indices: PCI=NREG-1, RAI=NREG-2, GPII=NREG-3, GPOI=NREG-4, MHI=NREG-5, MLO=NREG-6. For NREG=16 these are 15, 14, 13, 12, 11, 10.
- wdata by opcode:
  - 1100 LDI: zero-extended {raddr1,raddr2}.
  - 1101 DMR: dmem_out.
  - All others: alu_out.
- normal_op = (opcode[3:1] != 3'b111).
- Sub-ops, opcode 1111: 0001 CLF (F<=0, gpi_ovf<=0); 0010 CLE (E<=0); 0011 RET (new); 0100 VMW; 1000 DMW; any other is a NOP.
- Sub-ops, opcode 1110 (conditional skip when unsatisfied, compares unsigned):
  - 0001 JEQ: unsatisfied if a != b.
  - 0010 JGT: unsatisfied if !(a > b).
  - 0100 JFS: unsatisfied if !F.
  - 1000 JES: unsatisfied if !E.
  - Other sub-ops: satisfied, i.e. PC+1.
- PC update per non-stalled cycle, first match wins:
  1. normal_op && waddr==PCI: PC<=wdata; RA<=PC+1; push PC+1.
  2. RET with stack non-empty: PC<=top; pop.
  3. RET with stack empty: PC<=PC+1; rs_err<=1.
  4. Unsatisfied conditional: PC<=PC+2.
  5. Otherwise: PC<=PC+1.
  - All PC arithmetic wraps modulo 2^DW.
- General write: normal_op && waddr not in {GPII, RAI, PCI} -> reg[waddr]<=wdata.
- Return stack: circular, RS_DEPTH entries, with occupancy count 0..RS_DEPTH.
  - Push when full overwrites the oldest entry; count stays RS_DEPTH.
  - Push and pop are never simultaneous, because rules 1 and 2 are exclusive.
- GPI capture (ignores stall): gpi_we -> reg[GPII]<=gpi and F<=1. If F was already 1, gpi_ovf<=1.
  - gpi_we in the same cycle as CLF: set wins (F=1, gpi_ovf=0).
- E update:
  - CLE clears E.
  - Otherwise E<=E_out when not stalled.
  - E holds during stall.
- Stall=1 suppresses all of the following: PC/RA/stack/general-register updates, CLF, CLE, rs_err. vmem_we and dmem_we are forced to 0. a, b, mem_addr and gpo remain valid.
- Write strobes: vmem_we = (opcode==1111 && sub==0100 && !stall); dmem_we = (opcode==1111 && sub==1000 && !stall). Both are combinational.
- Latency:
  - Register writes are visible on a/b the cycle after the edge.
  - The PC change is visible 1 cycle after the instruction.
- DMR: synchronous memory, so software issues DMR twice or holds stall one cycle.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with gpi_we=1 and opcode=LDI -> pc=0, all regs 0, F=0, E=0, stack empty. After release, pc counts 0,1,2.
- LDI 0x5A to R3, then JEQ with R3 vs R3 and JEQ with R3 vs R0 -> R3=0x5A. First jump gives PC+1, second gives PC+2. JGT with 0x80 vs 0x7F is satisfied (unsigned).
- Call/return: PC=0x10, LDI 0x40 to R15 -> pc=0x40, R14=0x11. RET -> pc=0x11. Second RET (empty) -> pc=0x12, rs_err=1.
- Stack overflow (RS_DEPTH=4): 5 nested calls from PCs 1,2,3,4,5 -> 4 RETs yield 6,5,4,3. The 5th RET sets rs_err.
- GPI: gpi_we with 0x33 -> R13=0x33, F=1. Second gpi_we with 0x44 -> R13=0x44, gpi_ovf=1. CLF -> F=0, gpi_ovf=0. Attempting to write R13 via LDI leaves it unchanged.
- Stall: stall=1 during a DMW and an LDI to R15 -> dmem_we=0, pc and regs hold. A gpi_we during the stall is still captured. pc resumes +1 after stall drops.
- Parameter sweep: DW=16, NREG=32 -> mem_addr is 32 bits = {R27,R26}. LDI immediate is 10 bits zero-extended. PC wraps 0xFFFF->0x0000.
